// File: rtl/mult_booth_unit.sv
// Sequential signed multiplier for the multicycle CPU datapath.
// Radix-2 Booth recoding, one iteration per clock. The 2*WIDTH product is
// presented on hi/lo and is held until the next completed multiply.
module mult_booth_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mult_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [1:0] CMD_ACK   = 2'b10;
  localparam logic [1:0] CMD_ABORT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } stateT;

  stateT                    state;
  logic signed [WIDTH-1:0]  accA;
  logic signed [WIDTH-1:0]  mcand;
  logic        [WIDTH-1:0]  mulQ;
  logic                     qMinus1;
  logic        [CNT_W-1:0]  iterCnt;

  logic signed [WIDTH-1:0]  nextA;
  logic        [WIDTH-1:0]  nextQ;
  logic                     nextQm1;
  logic                     lastIter;

  // One Booth iteration: conditional add/subtract of the multiplicand into
  // the accumulator, then an arithmetic right shift of {A,Q,Q-1}. The sum is
  // kept one bit wider so that subtracting the most-negative multiplicand
  // still yields the true sign, which is what gets shifted into A's MSB.
  function automatic logic [2*WIDTH:0] boothStep(
    input logic signed [WIDTH-1:0] acc,
    input logic        [WIDTH-1:0] q,
    input logic                    qm1,
    input logic signed [WIDTH-1:0] m
  );
    logic signed [WIDTH:0] accExt;
    logic signed [WIDTH:0] mExt;
    logic signed [WIDTH:0] sum;
    accExt = {acc[WIDTH-1], acc};
    mExt   = {m[WIDTH-1], m};
    case ({q[0], qm1})
      2'b01:   sum = accExt + mExt;
      2'b10:   sum = accExt - mExt;
      default: sum = accExt;
    endcase
    return {sum[WIDTH:1], sum[0], q[WIDTH-1:1], q[0]};
  endfunction

  // Next iteration values of the Booth datapath.
  always_comb begin
    {nextA, nextQ, nextQm1} = boothStep(accA, mulQ, qMinus1, mcand);
  end

  assign lastIter = (iterCnt == CNT_W'(WIDTH - 1));

  // Control FSM and datapath registers; all outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      accA    <= '0;
      mcand   <= '0;
      mulQ    <= '0;
      qMinus1 <= 1'b0;
      iterCnt <= '0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mult_ctrl == CMD_START) begin
            mcand   <= op_a;
            mulQ    <= op_b;
            accA    <= '0;
            qMinus1 <= 1'b0;
            iterCnt <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end

        RUN: begin
          if (mult_ctrl == CMD_ABORT) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            accA    <= nextA;
            mulQ    <= nextQ;
            qMinus1 <= nextQm1;
            iterCnt <= iterCnt + 1'b1;
            if (lastIter) begin
              hi    <= nextA;
              lo    <= nextQ;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end
          end
        end

        DONE: begin
          if (mult_ctrl == CMD_START) begin
            // Implicit acknowledge plus a fresh start; hi/lo keep the old
            // product until the new one completes.
            mcand   <= op_a;
            mulQ    <= op_b;
            accA    <= '0;
            qMinus1 <= 1'b0;
            iterCnt <= '0;
            done    <= 1'b0;
            busy    <= 1'b1;
            state   <= RUN;
          end else if (mult_ctrl == CMD_ACK || mult_ctrl == CMD_ABORT) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_booth_unit.sv
// Testbench for mult_booth_unit: directed multiplies with hand-computed
// products, a scoreboard queue of expected {hi,lo} and a monitor that checks
// every rising done.
module tb_mult_booth_unit;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic [1:0]       mult_ctrl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  int tests = 0;
  int fails = 0;

  logic [2*WIDTH-1:0] sb[$];
  logic               prevDone = 1'b0;
  logic [WIDTH-1:0]   lastHi = '0;
  logic [WIDTH-1:0]   lastLo = '0;

  mult_booth_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .mult_ctrl (mult_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rising done must match the oldest expected product.
  always @(negedge clk) begin
    if (done && !prevDone) begin
      if (sb.size() == 0) begin
        check("unexpectedDone", 64'(done), 64'(0));
      end else begin
        logic [2*WIDTH-1:0] exp;
        exp = sb.pop_front();
        check("sbProduct", {hi, lo}, exp);
      end
    end
    prevDone = done;
  end

  // Present a start for one clock; returns at the negedge after the start edge.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    op_a      = a;
    op_b      = b;
    mult_ctrl = 2'b01;
    @(negedge clk);
    mult_ctrl = 2'b00;
    check("startBusy", 64'(busy), 64'(1));
    check("startDoneLow", 64'(done), 64'(0));
    check("startHoldHiLo", {hi, lo}, {lastHi, lastLo});
  endtask

  // Count busy negedges until busy drops, optionally disturbing the run.
  task automatic runBusy(input int chgCyc, input int restartCyc, input int abortCyc,
                         output int n);
    int guard;
    n = 0;
    guard = 0;
    while (busy && guard < 100) begin
      n++;
      guard++;
      mult_ctrl = 2'b00;
      if (n == chgCyc) begin
        op_a = 32'h1234_5678;
        op_b = 32'h9ABC_DEF0;
      end
      if (n == restartCyc) mult_ctrl = 2'b01;
      if (n == abortCyc) mult_ctrl = 2'b11;
      @(negedge clk);
    end
    mult_ctrl = 2'b00;
    if (guard >= 100) check("busyTimeout", 64'(guard), 64'(0));
  endtask

  task automatic ackCheck();
    mult_ctrl = 2'b10;
    @(negedge clk);
    mult_ctrl = 2'b00;
    check("ackDoneLow", 64'(done), 64'(0));
    check("ackBusyLow", 64'(busy), 64'(0));
    check("ackHoldHiLo", {hi, lo}, {lastHi, lastLo});
  endtask

  task automatic runMult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] eh, input logic [WIDTH-1:0] el,
                         input bit doAck);
    int n;
    sb.push_back({eh, el});
    issue(a, b);
    runBusy(0, 0, 0, n);
    check("busyCycles", 64'(n), 64'(32));
    check("doneSet", 64'(done), 64'(1));
    check("resultHiLo", {hi, lo}, {eh, el});
    lastHi = eh;
    lastLo = el;
    if (doAck) ackCheck();
  endtask

  initial begin
    #200000;
    $display("FAIL globalTimeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset     = 1'b1;
    mult_ctrl = 2'b00;
    op_a      = '0;
    op_b      = '0;
    repeat (3) @(negedge clk);
    check("rstBusy", 64'(busy), 64'(0));
    check("rstDone", 64'(done), 64'(0));
    check("rstHi", 64'(hi), 64'(0));
    check("rstLo", 64'(lo), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // Basic products, including the most-negative operand corners.
    runMult(32'd5, 32'd7, 32'h0000_0000, 32'h0000_0023, 1'b1);
    runMult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b1);
    runMult(32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b0);
    // Start directly from DONE (implicit acknowledge).
    runMult(32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    runMult(32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1);

    // Operand change at cycle 5 and repeated start at cycle 10 do not disturb 3*5.
    sb.push_back({32'h0, 32'hF});
    issue(32'd3, 32'd5);
    runBusy(5, 10, 0, n);
    check("noRestartCycles", 64'(n), 64'(32));
    check("noRestartHiLo", {hi, lo}, {32'h0, 32'hF});
    lastHi = 32'h0;
    lastLo = 32'hF;
    ackCheck();

    // Abort at cycle 20: product of 9*9 never appears.
    issue(32'd9, 32'd9);
    runBusy(0, 0, 20, n);
    check("abortCycle", 64'(n), 64'(20));
    check("abortBusy", 64'(busy), 64'(0));
    check("abortDone", 64'(done), 64'(0));
    check("abortHiLo", {hi, lo}, {32'h0, 32'hF});
    repeat (3) @(negedge clk);
    check("abortIdleDone", 64'(done), 64'(0));

    // Asynchronous reset mid-run, between clock edges.
    issue(32'd7, 32'd7);
    repeat (14) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midRstBusy", 64'(busy), 64'(0));
    check("midRstDone", 64'(done), 64'(0));
    check("midRstHi", 64'(hi), 64'(0));
    check("midRstLo", 64'(lo), 64'(0));
    lastHi = '0;
    lastLo = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("postRstIdle", 64'(busy), 64'(0));
    runMult(32'd6, 32'd6, 32'h0, 32'h24, 1'b1);

    repeat (2) @(negedge clk);
    check("sbEmpty", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
